mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mc_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencing, strobes and retired-instruction counter.
// Optional feature macro MC_CTRL_ILLEGAL_HALT_EN: undecoded instructions park the FSM in HALT until reset.
module mc_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   output logic [1:0]  wrsel,
   output logic [1:0]  wdsel,
   output logic        bsel,
   output logic        irwrite,
   output logic        pcwrite,
   output logic        regwrite,
   output logic        memwrite,
   output logic [1:0]  npcsel,
   output logic [2:0]  aluop,
   output logic        extop,
   output logic [2:0]  state,
   output logic [31:0] retired
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   logic [2:0]  state_q, state_d;
   logic [31:0] retired_q, retired_d;

   logic isRtype, isAddu, isSubu, isJr, isNop;
   logic isOri, isLw, isSw, isBeq, isLui, isJal;
   logic isLegal;

   assign isRtype = (opcode == 6'b000000);
   assign isAddu  = isRtype && (funct == 6'b100001);
   assign isSubu  = isRtype && (funct == 6'b100011);
   assign isJr    = isRtype && (funct == 6'b001000);
   assign isNop   = isRtype && (funct == 6'b000000);
   assign isOri   = (opcode == 6'b001101);
   assign isLw    = (opcode == 6'b100011);
   assign isSw    = (opcode == 6'b101011);
   assign isBeq   = (opcode == 6'b000100);
   assign isLui   = (opcode == 6'b001111);
   assign isJal   = (opcode == 6'b000011);
   assign isLegal = isAddu | isSubu | isJr | isNop | isOri | isLw | isSw | isBeq | isLui | isJal;

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            if (isJal || isJr || isNop) begin
               state_d = S_FETCH;
            end else if (isLegal) begin
               state_d = S_EXEC;
            end else begin
`ifdef MC_CTRL_ILLEGAL_HALT_EN
               state_d = S_HALT;
`else
               state_d = S_FETCH;
`endif
            end
         end
         S_EXEC: begin
            if (isLw || isSw) begin
               state_d = S_MEM;
            end else if (isAddu || isSubu || isOri || isLui) begin
               state_d = S_WB;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_MEM:    state_d = isLw ? S_WB : S_FETCH;
         S_WB:     state_d = S_FETCH;
`ifdef MC_CTRL_ILLEGAL_HALT_EN
         S_HALT:   state_d = S_HALT;
`else
         S_HALT:   state_d = S_FETCH;
`endif
         default:  state_d = S_FETCH;
      endcase
   end

   // An instruction retires whenever the FSM re-enters FETCH; FETCH itself never loops.
   assign retired_d = ((state_d == S_FETCH) && (state_q != S_FETCH)) ? retired_q + 32'd1 : retired_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         retired_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   // Outputs are gated by reset so an aborted instruction emits nothing while reset is high.
   always_comb begin
      wrsel    = 2'b00;
      wdsel    = 2'b00;
      bsel     = 1'b0;
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      npcsel   = 2'b00;
      aluop    = 3'b000;
      extop    = 1'b0;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               irwrite = 1'b1;
               pcwrite = 1'b1;
            end
            S_DECODE: begin
               if (isJal) begin
                  regwrite = 1'b1;
                  wrsel    = 2'b10;
                  wdsel    = 2'b10;
                  pcwrite  = 1'b1;
                  npcsel   = 2'b10;
               end else if (isJr) begin
                  pcwrite  = 1'b1;
                  npcsel   = 2'b11;
               end
            end
            S_EXEC: begin
               bsel  = isOri | isLui | isLw | isSw;
               extop = isLw | isSw | isBeq;
               if (isSubu || isBeq) begin
                  aluop = 3'b001;
               end else if (isOri) begin
                  aluop = 3'b010;
               end else if (isLui) begin
                  aluop = 3'b011;
               end
               if (isBeq) begin
                  pcwrite = zero;
                  npcsel  = 2'b01;
               end
            end
            S_MEM: begin
               memwrite = isSw;
            end
            S_WB: begin
               regwrite = 1'b1;
               wrsel    = (isAddu || isSubu) ? 2'b01 : 2'b00;
               wdsel    = isLw ? 2'b01 : 2'b00;
            end
            default: ;
         endcase
      end
   end

   assign state   = state_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl: walks each instruction class through its state sequence
// and checks the full control vector, retired count, reset abort and illegal-opcode handling.
module tb_mc_ctrl;

   logic        clk;
   logic        reset;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic [1:0]  wrsel, wdsel, npcsel;
   logic        bsel, irwrite, pcwrite, regwrite, memwrite, extop;
   logic [2:0]  aluop, state;
   logic [31:0] retired;

   int checks = 0;
   int errors = 0;

   mc_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .opcode   (opcode),
      .funct    (funct),
      .zero     (zero),
      .wrsel    (wrsel),
      .wdsel    (wdsel),
      .bsel     (bsel),
      .irwrite  (irwrite),
      .pcwrite  (pcwrite),
      .regwrite (regwrite),
      .memwrite (memwrite),
      .npcsel   (npcsel),
      .aluop    (aluop),
      .extop    (extop),
      .state    (state),
      .retired  (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Expected control vector: state, {ir,pc,reg,mem}, wrsel, wdsel, npcsel, bsel, extop, aluop.
   task automatic checkCtl(input string tag, input logic [2:0] st, input logic [3:0] strb,
                           input logic [1:0] ws, input logic [1:0] wd, input logic [1:0] np,
                           input logic bs, input logic ex, input logic [2:0] al);
      logic [17:0] obs;
      logic [17:0] exp;
      obs = {state, irwrite, pcwrite, regwrite, memwrite, wrsel, wdsel, npcsel, bsel, extop, aluop};
      exp = {st, strb, ws, wd, np, bs, ex, al};
      checkOutput(tag, {14'd0, obs}, {14'd0, exp});
   endtask

   task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z);
      opcode = op;
      funct  = fn;
      zero   = z;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(6'b000000, 6'b100001, 1'b0);
      tick();
      tick();
      checkCtl("reset_ctl", 3'd0, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000);
      checkOutput("reset_retired", retired, 32'd0);

      // addu: 0,1,2,4,0
      reset = 1'b0;
      #1;
      checkCtl("addu_fetch", 3'd0, 4'b1100, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000);
      tick();
      checkCtl("addu_decode", 3'd1, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000);
      tick();
      checkCtl("addu_exec", 3'd2, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000);
      tick();
      checkCtl("addu_wb", 3'd4, 4'b0010, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000);
      tick();
      checkCtl("addu_fetch2", 3'd0, 4'b1100, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000);
      checkOutput("addu_retired", retired, 32'd1);

      // lw: 0,1,2,3,4,0
      applyStimulus(6'b100011, 6'b000000, 1'b0);
      tick();
      checkCtl("lw_decode", 3'd1, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000);
      tick();
      checkCtl("lw_exec", 3'd2, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 3'b000);
      tick();
      checkCtl("lw_mem", 3'd3, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000);
      tick();
      checkCtl("lw_wb", 3'd4, 4'b0010, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 3'b000);
      tick();
      checkOutput("lw_retired", retired, 32'd2);

      // beq taken then not taken
      applyStimulus(6'b000100, 6'b000000, 1'b1);
      tick();
      tick();
      checkCtl("beq_t_exec", 3'd2, 4'b0100, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 3'b001);
      tick();
      checkCtl("beq_t_fetch", 3'd0, 4'b1100, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000);
      checkOutput("beq_t_retired", retired, 32'd3);
      applyStimulus(6'b000100, 6'b000000, 1'b0);
      tick();
      tick();
      checkCtl("beq_nt_exec", 3'd2, 4'b0000, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 3'b001);
      tick();
      checkOutput("beq_nt_retired", retired, 32'd4);

      // jal
      applyStimulus(6'b000011, 6'b000000, 1'b0);
      tick();
      checkCtl("jal_decode", 3'd1, 4'b0110, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0, 3'b000);
      tick();
      checkCtl("jal_fetch", 3'd0, 4'b1100, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000);
      checkOutput("jal_retired", retired, 32'd5);

      // jr
      applyStimulus(6'b000000, 6'b001000, 1'b0);
      tick();
      checkCtl("jr_decode", 3'd1, 4'b0100, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 3'b000);
      tick();
      checkOutput("jr_retired", retired, 32'd6);

      // ori
      applyStimulus(6'b001101, 6'b000000, 1'b0);
      tick();
      tick();
      checkCtl("ori_exec", 3'd2, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 3'b010);
      tick();
      checkCtl("ori_wb", 3'd4, 4'b0010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000);
      tick();
      checkOutput("ori_retired", retired, 32'd7);

      // subu
      applyStimulus(6'b000000, 6'b100011, 1'b0);
      tick();
      tick();
      checkCtl("subu_exec", 3'd2, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b001);
      tick();
      checkCtl("subu_wb", 3'd4, 4'b0010, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000);
      tick();

      // lui
      applyStimulus(6'b001111, 6'b000000, 1'b0);
      tick();
      tick();
      checkCtl("lui_exec", 3'd2, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 3'b011);
      tick();
      checkCtl("lui_wb", 3'd4, 4'b0010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000);
      tick();
      checkOutput("lui_retired", retired, 32'd9);

      // nop
      applyStimulus(6'b000000, 6'b000000, 1'b0);
      tick();
      checkCtl("nop_decode", 3'd1, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000);
      tick();
      checkOutput("nop_retired", retired, 32'd10);

      // sw complete
      applyStimulus(6'b101011, 6'b000000, 1'b0);
      tick();
      tick();
      checkCtl("sw_exec", 3'd2, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 3'b000);
      tick();
      checkCtl("sw_mem", 3'd3, 4'b0001, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000);
      tick();
      checkCtl("sw_fetch", 3'd0, 4'b1100, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000);
      checkOutput("sw_retired", retired, 32'd11);

      // sw aborted by reset right after entering MEM
      tick();
      tick();
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      checkCtl("swrst_ctl", 3'd0, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000);
      checkOutput("swrst_retired", retired, 32'd0);
      tick();
      reset = 1'b0;
      #1;
      checkCtl("swrst_fetch", 3'd0, 4'b1100, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000);
      tick();
      checkOutput("swrst_state", {29'd0, state}, 32'd1);
      checkOutput("swrst_retired2", retired, 32'd0);

      // illegal opcode 111111 from DECODE
      applyStimulus(6'b111111, 6'b000000, 1'b0);
      #1;
      checkCtl("ill_decode", 3'd1, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000);
`ifdef MC_CTRL_ILLEGAL_HALT_EN
      for (int i = 0; i < 10; i++) begin
         tick();
         checkCtl("ill_halt", 3'd5, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000);
      end
      checkOutput("ill_retired", retired, 32'd0);
`else
      tick();
      checkCtl("ill_fetch", 3'd0, 4'b1100, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000);
      checkOutput("ill_retired", retired, 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
